vga_color_scan: RTL
===================

# vga_color_scan

Raster scan generator that drives the VGA connector from the red, green and blue colour PIO registers. The Nios writes the three 8-bit colour PIOs; their `out_port` buses feed this block directly. It generates horizontal/vertical timing, blanking and pixel coordinates. It latches the colour inputs once per frame so a CPU write never tears a frame. Sits between the colour PIOs and the board's VGA DAC pins, in the system clock domain.

## Interface
Parameters:
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch, pixels
- `H_SYNC`, 96, horizontal sync width, pixels
- `H_BP`, 48, horizontal back porch, pixels
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch, lines
- `V_SYNC`, 2, vertical sync width, lines
- `V_BP`, 33, vertical back porch, lines
- `PIX_DIV`, 2, clk cycles per pixel (≥1)

Ports:
- `clk`  in  1  system clock
- `reset_n`  in  1  reset, asynchronous, active-low
- `red_in`  in  8  from red PIO `out_port`, same clk domain
- `green_in`  in  8  from green PIO `out_port`
- `blue_in`  in  8  from blue PIO `out_port`
- `vga_r`, `vga_g`, `vga_b`  out  8 each  pixel colour
- `vga_hs`  out  1  horizontal sync, active-low
- `vga_vs`  out  1  vertical sync, active-low
- `vga_blank_n`  out  1  high during visible area
- `pix_en`  out  1  one-clk pulse per pixel (DAC clock enable)
- `pix_x`  out  10  column of the pixel currently on the outputs
- `pix_y`  out  10  row of the pixel currently on the outputs
- `frame_start`  out  1  one-clk pulse when pixel (0,0) appears on the outputs

## Operation
- Derived values: `H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP` (default 800) and `V_TOTAL` (default 525).
- Divider: `div_cnt` counts 0..PIX_DIV-1 and wraps. `pix_en` is asserted when `div_cnt==PIX_DIV-1`. With PIX_DIV=1, `pix_en` is constantly high.
- Counters `h` and `v`:
  - Advance only on `pix_en`.
  - `h` wraps at H_TOTAL-1 to 0. `v` increments on `h` wrap.
  - `v` wraps at V_TOTAL-1 to 0.
- Output register: on each `pix_en` cycle, all pixel outputs load from the current (h,v), then the counters advance. Each pixel is therefore held for PIX_DIV clocks.
- `vga_hs`: 0 when `H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC`, else 1.
- `vga_vs`: the same rule applied to `v` with the V_* parameters.
- `vga_blank_n`: 1 when `h<H_ACTIVE && v<V_ACTIVE`.
- Colour outputs: shadow colour when `vga_blank_n` is 1, otherwise 0.
- `pix_x`/`pix_y`: equal to h/v, including during blanking.
- Shadow colour registers: load `{red_in,green_in,blue_in}` on the `pix_en` cycle where `h==H_TOTAL-1 && v==V_TOTAL-1`. A new colour therefore takes effect exactly at pixel (0,0) of the next frame. Input changes at any other time are ignored until that point.
- `frame_start`: registered. High for exactly one clk, in the same cycle the outputs first show (0,0).
- Reset (asynchronous, any time):
  - `div_cnt`, `h`, `v`, shadow, `pix_x`, `pix_y` = 0
  - `vga_r/g/b` = 0, `vga_blank_n` = 0
  - `vga_hs` = `vga_vs` = 1
  - `frame_start` = 0, `pix_en` = 0
  - Scanning restarts from (0,0) after release. No partial-frame state survives.

## Timing
- Latency from counter state to pins: 1 clk, registered on the `pix_en` edge. `pix_en` itself is combinational from `div_cnt`.
- First `pix_en` occurs PIX_DIV clk edges after `reset_n` deasserts. The output register loads (0,0) on that edge and `frame_start` pulses in the following cycle.
- `frame_start` pulses once every H_TOTAL·V_TOTAL·PIX_DIV clks: 840 000 at defaults.
- `vga_hs` low 96 pixels per line, starting at pixel 656 (defaults).
- `vga_vs` low for lines 490–491 inclusive, for full lines.
- A colour write in the same clk as the shadow-load edge is captured (inputs sampled on that edge). A write one clk later waits a full frame.
- No handshake on the colour inputs. They are level registers, sampled once per frame.

## Test plan
1. Reset: hold `reset_n`=0 with random colour inputs → `vga_hs`=`vga_vs`=1, `vga_blank_n`=0, rgb=0, `pix_x`=`pix_y`=0; after release, first `frame_start` at clk PIX_DIV+1.
2. Line timing (defaults): measure `vga_hs` → period 1600 clk, low for 192 clk, falling edge at `pix_x`=656; `vga_blank_n` high for `pix_x` 0..639 only.
3. Frame timing: `vga_vs` low exactly while `pix_y`∈{490,491}; `frame_start` interval 840 000 clk; rgb=0 on every line ≥480.
4. Tear-free update: red/green/blue = 0x00/0x00/0x10, run to frame 1, write `blue_in`=0xFF at `pix_y`=100 → `vga_b` stays 0x10 until the next `frame_start`, then 0xFF from (0,0) on.
5. Boundary write: change `green_in` to 0xAA on exactly the shadow-load edge → 0xAA visible at (0,0) of the next frame; repeat one clk later → visible one frame later.
6. Mid-frame reset and PIX_DIV=1 variant: assert `reset_n` at (300,200) → outputs reach reset values without waiting for a clk edge, and the scan resumes at (0,0). With PIX_DIV=1, `pix_en` stays high and the line period is 800 clk.

Source files
------------

// File: rtl/vga_color_scan_if.sv
// Colour PIO inputs and VGA pin outputs of the raster scan generator.
// master drives the colour registers; slave is the scan generator itself.
interface vga_color_scan_if;
    logic [7:0] red_in;
    logic [7:0] green_in;
    logic [7:0] blue_in;
    logic [7:0] vga_r;
    logic [7:0] vga_g;
    logic [7:0] vga_b;
    logic       vga_hs;
    logic       vga_vs;
    logic       vga_blank_n;
    logic       pix_en;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic       frame_start;

    modport master (
        output red_in, green_in, blue_in,
        input  vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n,
        input  pix_en, pix_x, pix_y, frame_start
    );

    modport slave (
        input  red_in, green_in, blue_in,
        output vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n,
        output pix_en, pix_x, pix_y, frame_start
    );
endinterface

// File: rtl/vga_color_scan.sv
// VGA raster scan generator: pixel divider, h/v counters, registered sync/blank/colour
// outputs, and a colour shadow reloaded once per frame so CPU writes never tear.
module vga_color_scan #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned PIX_DIV  = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    vga_color_scan_if.slave   bus
);
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
    localparam logic [9:0] H_SS   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SE   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
    localparam logic [9:0] V_SS   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SE   = 10'(V_ACTIVE + V_FP + V_SYNC);

    localparam int unsigned    DW       = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam logic [DW-1:0]  DIV_LAST = DW'(PIX_DIV - 1);

    logic [DW-1:0] div_q, div_d;
    logic [9:0]    h_q, h_d;
    logic [9:0]    v_q, v_d;
    logic [23:0]   shadow_q;
    logic [23:0]   rgb_q, rgb_d;
    logic          hs_q, hs_d;
    logic          vs_q, vs_d;
    logic          blank_n_q, blank_n_d;
    logic [9:0]    x_q, y_q;
    logic          fs_q, fs_d;
    logic          pix_en;
    logic          frame_last;

    // pix_en is gated by reset_n so it is low while held in reset; with PIX_DIV=1
    // it goes high immediately on release and (0,0) loads on the first edge.
    always_comb begin
        pix_en     = reset_n && (div_q == DIV_LAST);
        div_d      = pix_en ? '0 : div_q + 1'b1;
        frame_last = (h_q == H_LAST) && (v_q == V_LAST);

        h_d = h_q;
        v_d = v_q;
        if (pix_en) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
            end else begin
                h_d = h_q + 10'd1;
            end
        end

        blank_n_d = (h_q < H_VIS) && (v_q < V_VIS);
        hs_d      = !((h_q >= H_SS) && (h_q < H_SE));
        vs_d      = !((v_q >= V_SS) && (v_q < V_SE));
        rgb_d     = blank_n_d ? shadow_q : '0;
        fs_d      = pix_en && (h_q == '0) && (v_q == '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q     <= '0;
            h_q       <= '0;
            v_q       <= '0;
            shadow_q  <= '0;
            rgb_q     <= '0;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            blank_n_q <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            fs_q      <= 1'b0;
        end else begin
            div_q <= div_d;
            fs_q  <= fs_d;
            h_q   <= h_d;
            v_q   <= v_d;
            if (pix_en) begin
                rgb_q     <= rgb_d;
                hs_q      <= hs_d;
                vs_q      <= vs_d;
                blank_n_q <= blank_n_d;
                x_q       <= h_q;
                y_q       <= v_q;
                // The last pixel of the frame is blank, so the reload is never visible
                // before (0,0) of the following frame.
                if (frame_last) begin
                    shadow_q <= {bus.red_in, bus.green_in, bus.blue_in};
                end
            end
        end
    end

    assign bus.vga_r       = rgb_q[23:16];
    assign bus.vga_g       = rgb_q[15:8];
    assign bus.vga_b       = rgb_q[7:0];
    assign bus.vga_hs      = hs_q;
    assign bus.vga_vs      = vs_q;
    assign bus.vga_blank_n = blank_n_q;
    assign bus.pix_en      = pix_en;
    assign bus.pix_x       = x_q;
    assign bus.pix_y       = y_q;
    assign bus.frame_start = fs_q;
endmodule
